// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM generator/capture family.
package pwm_pkg;

  typedef enum logic [1:0] {CAP_IDLE, CAP_ARM, CAP_MEASURE} cap_state_t;

  // Largest count representable in an XLEN+1 bit measurement.
  function automatic int unsigned cap_max(input int unsigned xlen);
    return (32'd1 << (xlen + 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer with synchronous active-high reset; N=0 is a plain wire.
module sync_ff #(
  parameter int unsigned N = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  generate
    if (N == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = i_clk ^ i_rst;
      assign o_q      = i_d;
    end else begin : g_sync
      logic [N-1:0] r_stages;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_stages <= '0;
        end else begin
          r_stages[0] <= i_d;
          for (int i = 1; i < int'(N); i++) begin
            r_stages[i] <= r_stages[i-1];
          end
        end
      end

      assign o_q = r_stages[N-1];
    end
  endgenerate

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period and high time in clock cycles, publishing once per period
// with a one-cycle valid strobe and a sticky overflow flag on loss of toggling.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned XLEN        = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_signal,
  input  logic          i_clear_ovf,
  output logic [XLEN:0] o_period,
  output logic [XLEN:0] o_high_cnt,
  output logic          o_valid,
  output logic          o_overflow,
  output logic          o_level
);

  localparam int unsigned W = XLEN + 1;
  localparam logic [W-1:0] MaxCnt = W'(cap_max(XLEN));
  localparam logic [W-1:0] One    = W'(1);

  cap_state_t   r_state;
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_hcnt;
  logic [W-1:0] r_period;
  logic [W-1:0] r_high_cnt;
  logic         r_valid;
  logic         r_overflow;
  logic         r_level;
  logic         r_s_d;

  logic         w_s;
  logic         w_rise;

  sync_ff #(
    .N (SYNC_STAGES)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_signal),
    .o_q   (w_s)
  );

  assign w_rise = w_s & ~r_s_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= CAP_IDLE;
      r_cnt      <= '0;
      r_hcnt     <= '0;
      r_period   <= '0;
      r_high_cnt <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_level    <= 1'b0;
      r_s_d      <= 1'b0;
    end else begin
      r_s_d   <= w_s;
      r_level <= w_s;
      r_valid <= 1'b0;
      // A timeout later in this block overrides the clear.
      if (i_clear_ovf) begin
        r_overflow <= 1'b0;
      end
      if (!i_en) begin
        r_state <= CAP_IDLE;
        r_cnt   <= '0;
        r_hcnt  <= '0;
      end else begin
        unique case (r_state)
          CAP_IDLE: begin
            r_state <= CAP_ARM;
          end
          CAP_ARM: begin
            if (w_rise) begin
              r_cnt   <= One;
              r_hcnt  <= One;
              r_state <= CAP_MEASURE;
            end
          end
          CAP_MEASURE: begin
            if (w_rise) begin
              r_period   <= r_cnt;
              r_high_cnt <= r_hcnt;
              r_valid    <= 1'b1;
              r_cnt      <= One;
              r_hcnt     <= One;
            end else if (r_cnt == MaxCnt) begin
              r_overflow <= 1'b1;
              r_state    <= CAP_ARM;
            end else begin
              r_cnt  <= r_cnt + One;
              r_hcnt <= r_hcnt + {{(W-1){1'b0}}, w_s};
            end
          end
          default: begin
            r_state <= CAP_IDLE;
          end
        endcase
      end
    end
  end

  assign o_period   = r_period;
  assign o_high_cnt = r_high_cnt;
  assign o_valid    = r_valid;
  assign o_overflow = r_overflow;
  assign o_level    = r_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture with XLEN=8, SYNC_STAGES=2.
module tb_pwm_capture;

  localparam int unsigned XLEN = 8;

  logic          clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_en = 1'b0;
  logic          i_signal = 1'b0;
  logic          i_clear_ovf = 1'b0;
  logic [XLEN:0] o_period;
  logic [XLEN:0] o_high_cnt;
  logic          o_valid;
  logic          o_overflow;
  logic          o_level;

  int n_tests = 0;
  int n_fail  = 0;

  // Recorder state, updated by step()
  int cyc;
  int v_count;
  int v_first;
  int ovf_first;
  int fp, fh, lp, lh;

  pwm_capture #(
    .XLEN        (XLEN),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_signal    (i_signal),
    .i_clear_ovf (i_clear_ovf),
    .o_period    (o_period),
    .o_high_cnt  (o_high_cnt),
    .o_valid     (o_valid),
    .o_overflow  (o_overflow),
    .o_level     (o_level)
  );

  always #5 clk = ~clk;

  task automatic clear_rec(input int start);
    cyc       = start;
    v_count   = 0;
    v_first   = -1;
    ovf_first = -1;
    fp = 0; fh = 0; lp = 0; lh = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (o_valid) begin
      if (v_count == 0) begin
        v_first = cyc;
        fp      = int'(o_period);
        fh      = int'(o_high_cnt);
      end
      lp = int'(o_period);
      lh = int'(o_high_cnt);
      v_count++;
    end
    if (o_overflow && ovf_first < 0) ovf_first = cyc;
    cyc++;
  endtask

  task automatic run_pwm(input int per, input int hi, input int start, input int n);
    for (int i = 0; i < n; i++) begin
      i_signal = ((start + i) % per) < hi;
      step();
    end
  endtask

  // Reset, then leave the block enabled with the input low long enough to reach ARM.
  task automatic do_reset();
    i_signal    = 1'b0;
    i_clear_ovf = 1'b0;
    i_en        = 1'b1;
    i_rst       = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_reset();
    i_en     = 1'b0;
    i_signal = 1'b1;
    i_rst    = 1'b1;
    step();
    step();
    n_tests++;
    if (o_period !== 9'd0) begin
      n_fail++; $display("FAIL reset_period: got %0d want 0", o_period);
    end
    n_tests++;
    if (o_high_cnt !== 9'd0) begin
      n_fail++; $display("FAIL reset_high: got %0d want 0", o_high_cnt);
    end
    n_tests++;
    if ({o_valid, o_overflow, o_level} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {o_valid, o_overflow, o_level});
    end
    i_rst    = 1'b0;
    i_signal = 1'b0;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_level_latency();
    logic l1, l2;
    i_en     = 1'b0;
    i_signal = 1'b1;
    step();
    step();
    l1 = o_level;
    step();
    l2 = o_level;
    n_tests++;
    if ({l1, l2} !== 2'b01) begin
      n_fail++; $display("FAIL level_latency: got %b want 01", {l1, l2});
    end
    i_signal = 1'b0;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_basic();
    do_reset();
    clear_rec(0);
    run_pwm(10, 3, 0, 60);
    n_tests++;
    if (v_first != 12) begin
      n_fail++; $display("FAIL basic_first_valid: got cycle %0d want 12", v_first);
    end
    n_tests++;
    if (v_count != 5) begin
      n_fail++; $display("FAIL basic_count: got %0d want 5", v_count);
    end
    n_tests++;
    if (fp != 10 || fh != 3 || lp != 10 || lh != 3) begin
      n_fail++;
      $display("FAIL basic_values: got %0d/%0d..%0d/%0d want 10/3", fp, fh, lp, lh);
    end
  endtask

  task automatic test_change();
    clear_rec(60);
    run_pwm(7, 5, 0, 50);
    n_tests++;
    if (v_count != 7 || v_first != 62) begin
      n_fail++; $display("FAIL change_count: got %0d at %0d want 7 at 62", v_count, v_first);
    end
    n_tests++;
    if (fp != 10 || fh != 3) begin
      n_fail++; $display("FAIL change_transition: got %0d/%0d want 10/3", fp, fh);
    end
    n_tests++;
    if (lp != 7 || lh != 5) begin
      n_fail++; $display("FAIL change_steady: got %0d/%0d want 7/5", lp, lh);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    clear_rec(0);
    run_pwm(10, 3, 0, 20);
    run_pwm(1, 1, 0, 520);
    n_tests++;
    if (ovf_first != 533) begin
      n_fail++; $display("FAIL ovf_timing: got cycle %0d want 533", ovf_first);
    end
    n_tests++;
    if (v_count != 2 || o_period !== 9'd10 || o_high_cnt !== 9'd3) begin
      n_fail++;
      $display("FAIL ovf_hold: got %0d valids %0d/%0d want 2 valids 10/3", v_count, o_period,
               o_high_cnt);
    end
    n_tests++;
    if (o_level !== 1'b1 || o_overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_level: got level=%b ovf=%b want 1 1", o_level, o_overflow);
    end
    i_clear_ovf = 1'b1;
    step();
    i_clear_ovf = 1'b0;
    step();
    n_tests++;
    if (o_overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %b want 0", o_overflow);
    end
  endtask

  task automatic test_max_period();
    do_reset();
    clear_rec(0);
    run_pwm(511, 200, 0, 1100);
    n_tests++;
    if (v_count != 2 || v_first != 513) begin
      n_fail++; $display("FAIL max511_count: got %0d at %0d want 2 at 513", v_count, v_first);
    end
    n_tests++;
    if (lp != 511 || lh != 200 || ovf_first != -1) begin
      n_fail++;
      $display("FAIL max511_values: got %0d/%0d ovf_at=%0d want 511/200 ovf_at=-1", lp, lh,
               ovf_first);
    end
    do_reset();
    clear_rec(0);
    run_pwm(512, 200, 0, 1100);
    n_tests++;
    if (v_count != 0 || ovf_first != 513 || o_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL max512: got %0d valids ovf_at=%0d ovf=%b want 0 valids ovf_at=513 ovf=1",
               v_count, ovf_first, o_overflow);
    end
  endtask

  task automatic test_clear_same_cycle();
    do_reset();
    clear_rec(0);
    i_signal = 1'b1;
    for (int j = 0; j < 516; j++) begin
      i_clear_ovf = (j >= 510 && j <= 513);
      step();
    end
    i_clear_ovf = 1'b0;
    n_tests++;
    if (ovf_first != 513 || o_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got ovf_at=%0d ovf=%b want 513 1", ovf_first, o_overflow);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    clear_rec(0);
    run_pwm(10, 3, 0, 23);
    n_tests++;
    if (o_level !== 1'b1 || o_period !== 9'd10) begin
      n_fail++; $display("FAIL pre_rst: got level=%b period=%0d want 1 10", o_level, o_period);
    end
    i_signal = 1'b0;
    i_rst    = 1'b1;
    step();
    i_rst = 1'b0;
    n_tests++;
    if ({o_period, o_high_cnt} !== 18'd0 || {o_valid, o_overflow, o_level} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_mid: got %0d/%0d flags=%b want 0/0 000", o_period, o_high_cnt,
               {o_valid, o_overflow, o_level});
    end
    clear_rec(24);
    run_pwm(10, 3, 24, 32);
    n_tests++;
    if (v_first != 42 || v_count != 2 || lp != 10 || lh != 3) begin
      n_fail++;
      $display("FAIL rst_recover: got first=%0d count=%0d %0d/%0d want 42 2 10/3", v_first,
               v_count, lp, lh);
    end
  endtask

  task automatic test_en_drop();
    do_reset();
    clear_rec(0);
    run_pwm(10, 3, 0, 15);
    n_tests++;
    if (v_count != 1 || v_first != 12) begin
      n_fail++; $display("FAIL en_pre: got %0d at %0d want 1 at 12", v_count, v_first);
    end
    clear_rec(15);
    i_en = 1'b0;
    run_pwm(10, 3, 15, 3);
    n_tests++;
    if (o_period !== 9'd10 || o_high_cnt !== 9'd3) begin
      n_fail++; $display("FAIL en_hold: got %0d/%0d want 10/3", o_period, o_high_cnt);
    end
    i_en = 1'b1;
    run_pwm(10, 3, 18, 42);
    n_tests++;
    if (v_first != 32 || v_count != 3) begin
      n_fail++; $display("FAIL en_resume: got first=%0d count=%0d want 32 3", v_first, v_count);
    end
  endtask

  initial begin
    clear_rec(0);
    test_reset();
    test_level_latency();
    test_basic();
    test_change();
    test_overflow();
    test_max_period();
    test_clear_same_cycle();
    test_rst_mid();
    test_en_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures the period and high time of a PWM waveform, cycle-accurately, in clock cycles. It sits directly downstream of the `pwm` generator, or of any external PWM pin. It provides closed-loop checking and telemetry for duty-cycle control. Results are published once per period with a one-cycle valid strobe, and loss of toggling is flagged.

## Interface
- `XLEN`, default 8: measurement width is XLEN+1 bits, matching the generator's `duty_cycle` width. Maximum measurable value is M = 2^(XLEN+1)-1 (511 at default).
- `SYNC_STAGES`, default 2: input synchronizer depth, legal range 0..3. A value of 0 bypasses synchronization and is for on-chip sources only.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  enables capture. When low, the block is idle.
- `signal`  in  1  PWM input.
- `clear_ovf`  in  1  clears `overflow`.
- `period`  out  XLEN+1  cycles between the last two rising edges.
- `high_cnt`  out  XLEN+1  high cycles within that period.
- `valid`  out  1  one-cycle strobe when `period`/`high_cnt` update.
- `overflow`  out  1  sticky flag: no rising edge was seen within M cycles.
- `level`  out  1  synchronized input level.

## Operation
- `s` is `signal` after SYNC_STAGES flops. `s_d` is `s` delayed one cycle. `rise = s & ~s_d`. The flops and `s_d` run in every state.
- `level` = `s`, registered.
- FSM states are IDLE, ARM and MEASURE. There are two counters: `cnt` and `hcnt`, each XLEN+1 bits.
- IDLE: `cnt` and `hcnt` are 0. If `en`=1, go to ARM.
- ARM: wait for `rise`. On `rise`: load `cnt`=1, load `hcnt`=1, go to MEASURE. No timeout applies in ARM.
- MEASURE with no `rise`:
  - `cnt` increments by 1.
  - `hcnt` increments by `s`.
  - `hcnt` never exceeds `cnt`, so no saturation is needed.
- MEASURE on `rise`:
  - Set `period` to `cnt` and `high_cnt` to `hcnt`.
  - Pulse `valid`.
  - Reload `cnt` and `hcnt` to 1. Stay in MEASURE.
- MEASURE, `cnt`==M and no `rise`: set `overflow`, go to ARM. `period` and `high_cnt` hold their values and no `valid` is issued.
- MEASURE, `cnt`==M together with `rise`: this is a normal publish with `period`=M. No overflow is raised.
- The first partial period after entering ARM is always discarded. The first `valid` follows the second observed rising edge.
- `en` low in any state: go to IDLE next edge. Outputs other than `valid` and `level` hold. `valid` is 0.
- `overflow` is set by timeout and cleared by `clear_ovf`. If both happen in the same cycle, set wins.
- Reset values: `period`=0, `high_cnt`=0, `valid`=0, `overflow`=0, `level`=0. State is IDLE; all synchronizer flops, `s_d`, `cnt` and `hcnt` are 0.

## Timing
- All outputs are registered.
- Let E be the edge at which `signal` is first sampled high. `valid` and the new values appear after edge E+SYNC_STAGES.
- `level` follows `signal` with a latency of SYNC_STAGES+1 edges.
- `valid` is high for exactly one cycle per published period. Minimum spacing between strobes is 2 cycles, for a signal toggling every cycle.
- `rst` mid-measurement: all state and outputs take their reset values at the next edge. The block needs `en` and two rises to produce the next `valid`.
- `en` re-asserted while `signal` is already high: no capture until the next genuine rising edge.

## Structure
- The shared package `pwm_pkg` holds:
  - `typedef enum logic [1:0] {CAP_IDLE, CAP_ARM, CAP_MEASURE} cap_state_t`.
  - The helper constant function for M.
- One sub-module, `sync_ff`:
  - Parameterized N-stage synchronizer with N=0 as a wire.
  - Synchronous active-high reset to 0.
  - Reusable by other pin-facing blocks.
- The counters, FSM and output registers stay in `pwm_capture`. The estimated size is about 150 lines.

## Test plan
- Driven by `pwm` with XLEN=8, `ampl`=3, `duty_cycle`=10, SYNC_STAGES=2 and `en`=1: `valid` every 10 cycles with `period`=10 and `high_cnt`=3. No `valid` before the second rising edge.
- Same setup, then `duty_cycle` changed to 7 and `ampl` to 5: after one transitional value, a steady `period`=7 and `high_cnt`=5.
- `ampl`=10, `duty_cycle`=10, so the input is constant high after one period:
  - `overflow`=1 exactly 511 cycles after the last rise; state is ARM.
  - `period` and `high_cnt` keep their last values; `level`=1.
  - `clear_ovf` pulse then gives `overflow`=0.
- Input with a period of exactly 511 and high time 200: `valid` with `period`=511 and `high_cnt`=200, `overflow` stays 0. A period of 512 gives `overflow`=1.
- `clear_ovf` asserted in the same cycle as the timeout: `overflow` stays 1.
- `rst` pulsed mid-period: all outputs are 0 at the next edge and the next `valid` comes only after two further rises. `en` dropped for 3 cycles mid-period: no `valid` is issued for the interrupted period.
